// File: rtl/bp_btb.sv
// bp_btb: direct-mapped branch target buffer with 2-bit direction counters.
// Optional BP_STATS_EN adds saturating lookup/mispredict counters.
module bp_btb #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4,
    parameter int ADDR_W  = 32,
    parameter int TAG_W   = ADDR_W - IDX_W - 2
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] f_pc,
    output logic              f_hit,
    output logic              f_taken,
    output logic [ADDR_W-1:0] f_npc,
    input  logic              u_valid,
    input  logic [ADDR_W-1:0] u_pc,
    input  logic              u_taken,
    input  logic [ADDR_W-1:0] u_target,
    input  logic              u_pred_taken,
    input  logic [ADDR_W-1:0] u_pred_npc,
`ifdef BP_STATS_EN
    input  logic              stat_clr,
    output logic [31:0]       stat_lookups,
    output logic [31:0]       stat_mispred,
`endif
    output logic              u_mispredict,
    output logic [ADDR_W-1:0] u_fix_pc
);

    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [ADDR_W-1:0]  r_target [ENTRIES];
    logic [1:0]         r_ctr    [ENTRIES];

    logic [IDX_W-1:0] w_f_idx;
    logic [TAG_W-1:0] w_f_tag;
    logic [IDX_W-1:0] w_u_idx;
    logic [TAG_W-1:0] w_u_tag;
    logic             w_f_match;
    logic             w_u_hit;
    logic [1:0]       w_u_ctr;
    logic             w_unused_pred_taken;

    assign w_f_idx = f_pc[IDX_W+1:2];
    assign w_f_tag = f_pc[ADDR_W-1:IDX_W+2];
    assign w_u_idx = u_pc[IDX_W+1:2];
    assign w_u_tag = u_pc[ADDR_W-1:IDX_W+2];

    // The npc comparison already covers direction errors.
    assign w_unused_pred_taken = u_pred_taken;

    assign w_f_match = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
    assign f_hit     = resetn && w_f_match;
    assign f_taken   = f_hit && r_ctr[w_f_idx][1];
    assign f_npc     = f_taken ? r_target[w_f_idx] : f_pc + ADDR_W'(4);

    assign w_u_hit = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);
    assign w_u_ctr = r_ctr[w_u_idx];

    assign u_fix_pc     = u_taken ? u_target : u_pc + ADDR_W'(4);
    assign u_mispredict = resetn && u_valid && (u_pred_npc != u_fix_pc);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_ctr[i] <= 2'b01;
            end
        end else if (u_valid) begin
            if (w_u_hit) begin
                if (u_taken) begin
                    if (w_u_ctr != 2'b11) begin
                        r_ctr[w_u_idx] <= w_u_ctr + 2'b01;
                    end
                    r_target[w_u_idx] <= u_target;
                end else if (w_u_ctr != 2'b00) begin
                    r_ctr[w_u_idx] <= w_u_ctr - 2'b01;
                end
            end else if (u_taken) begin
                r_valid[w_u_idx]  <= 1'b1;
                r_tag[w_u_idx]    <= w_u_tag;
                r_target[w_u_idx] <= u_target;
                r_ctr[w_u_idx]    <= 2'b10;
            end
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] r_lookups;
    logic [31:0] r_mispred;

    // Clear takes priority over a same-cycle increment.
    always_ff @(posedge clock) begin
        if (!resetn || stat_clr) begin
            r_lookups <= '0;
            r_mispred <= '0;
        end else begin
            if (u_valid && (r_lookups != 32'hFFFF_FFFF)) begin
                r_lookups <= r_lookups + 32'd1;
            end
            if (u_mispredict && (r_mispred != 32'hFFFF_FFFF)) begin
                r_mispred <= r_mispred + 32'd1;
            end
        end
    end

    assign stat_lookups = r_lookups;
    assign stat_mispred = r_mispred;
`endif

endmodule

// File: tb/tb_bp_btb.sv
// tb_bp_btb: directed sequences, a mispredict vector table and a randomized
// run against an array-based reference of the BTB.
module tb_bp_btb;
    localparam int ENTRIES = 16;
    localparam int IDX_W   = 4;
    localparam int ADDR_W  = 32;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] f_pc = '0;
    logic        f_hit;
    logic        f_taken;
    logic [31:0] f_npc;
    logic        u_valid = 1'b0;
    logic [31:0] u_pc = '0;
    logic        u_taken = 1'b0;
    logic [31:0] u_target = '0;
    logic        u_pred_taken = 1'b0;
    logic [31:0] u_pred_npc = '0;
    logic        u_mispredict;
    logic [31:0] u_fix_pc;
`ifdef BP_STATS_EN
    logic        stat_clr = 1'b0;
    logic [31:0] stat_lookups;
    logic [31:0] stat_mispred;
`endif

    int checks = 0;
    int errors = 0;

    bp_btb #(.ENTRIES(ENTRIES), .IDX_W(IDX_W), .ADDR_W(ADDR_W)) dut (
        .clock(clock), .resetn(resetn), .f_pc(f_pc),
        .f_hit(f_hit), .f_taken(f_taken), .f_npc(f_npc),
        .u_valid(u_valid), .u_pc(u_pc), .u_taken(u_taken),
        .u_target(u_target), .u_pred_taken(u_pred_taken),
        .u_pred_npc(u_pred_npc),
`ifdef BP_STATS_EN
        .stat_clr(stat_clr), .stat_lookups(stat_lookups),
        .stat_mispred(stat_mispred),
`endif
        .u_mispredict(u_mispredict), .u_fix_pc(u_fix_pc)
    );

    always #5 clock = ~clock;

    // Reference model: one record per index, plain integers.
    bit          m_valid [ENTRIES];
    int unsigned m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];

    function automatic int unsigned idx_of(logic [31:0] pc);
        return (pc / 4) % ENTRIES;
    endfunction

    function automatic int unsigned tag_of(logic [31:0] pc);
        return pc / (4 * ENTRIES);
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0;
            m_ctr[i] = 1;
        end
    endfunction

    function automatic void m_predict(input logic [31:0] pc, output bit hit,
                                      output bit tk, output logic [31:0] npc);
        int unsigned i = idx_of(pc);
        hit = m_valid[i] && (m_tag[i] == tag_of(pc));
        tk  = hit && (m_ctr[i] >= 2);
        npc = tk ? m_tgt[i] : pc + 32'd4;
    endfunction

    function automatic void m_update(input logic [31:0] pc, input bit tk,
                                     input logic [31:0] tgt);
        int unsigned i = idx_of(pc);
        if (m_valid[i] && m_tag[i] == tag_of(pc)) begin
            if (tk) begin
                m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                m_tgt[i] = tgt;
            end else begin
                m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
            end
        end else if (tk) begin
            m_valid[i] = 1;
            m_tag[i] = tag_of(pc);
            m_tgt[i] = tgt;
            m_ctr[i] = 2;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        u_valid = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk,
                       input logic [31:0] tgt);
        u_valid = 1'b1;
        u_pc = pc;
        u_taken = tk;
        u_target = tgt;
        u_pred_taken = 1'b0;
        u_pred_npc = pc + 32'd4;
        tick();
        u_valid = 1'b0;
    endtask

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        t;
        logic [31:0] tgt;
        logic        pt;
        logic [31:0] pnpc;
        logic        em;
        logic [31:0] efix;
    } vec_t;

    vec_t vecs[6];

    logic [31:0] pool[6];

    initial begin
        bit          hit;
        bit          tk;
        logic [31:0] npc;
        logic [31:0] fix;

        vecs[0] = '{1'b1, 32'h0040_0010, 1'b0, 32'h0040_0100, 1'b1,
                    32'h0040_0100, 1'b1, 32'h0040_0014};
        vecs[1] = '{1'b1, 32'h0040_0010, 1'b1, 32'h0040_0180, 1'b1,
                    32'h0040_0100, 1'b1, 32'h0040_0180};
        vecs[2] = '{1'b1, 32'h0040_0010, 1'b1, 32'h0040_0100, 1'b1,
                    32'h0040_0100, 1'b0, 32'h0040_0100};
        vecs[3] = '{1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0000_0040, 1'b0,
                    32'h0000_0000, 1'b0, 32'h0000_0000};
        vecs[4] = '{1'b0, 32'h0040_0010, 1'b0, 32'h0040_0100, 1'b1,
                    32'h0040_0100, 1'b0, 32'h0040_0014};
        vecs[5] = '{1'b1, 32'h0040_0020, 1'b0, 32'h0040_0400, 1'b0,
                    32'h0040_0024, 1'b0, 32'h0040_0024};

        pool[0] = 32'h0040_0010;
        pool[1] = 32'h0040_0050;
        pool[2] = 32'h0040_0014;
        pool[3] = 32'h1000_0010;
        pool[4] = 32'hFFFF_FFFC;
        pool[5] = 32'h0040_0090;

        // Reset state
        do_reset();
        f_pc = 32'h0040_0010;
        #1;
        chk("rst_hit", f_hit, 0);
        chk("rst_taken", f_taken, 0);
        chk("rst_npc", f_npc, 32'h0040_0014);
        chk("rst_mis", u_mispredict, 0);
        f_pc = 32'hFFFF_FFFC;
        #1;
        chk("wrap_npc", f_npc, 32'h0000_0000);

        // Allocation
        f_pc = 32'h0040_0010;
        upd(32'h0040_0010, 1'b1, 32'h0040_0100);
        chk("alloc_hit", f_hit, 1);
        chk("alloc_taken", f_taken, 1);
        chk("alloc_npc", f_npc, 32'h0040_0100);

        // Down to 00 and saturate
        upd(32'h0040_0010, 1'b0, 32'h0);
        chk("nt1_taken", f_taken, 0);
        chk("nt1_hit", f_hit, 1);
        upd(32'h0040_0010, 1'b0, 32'h0);
        upd(32'h0040_0010, 1'b0, 32'h0);
        chk("nt3_hit", f_hit, 1);
        chk("nt3_taken", f_taken, 0);
        chk("nt3_npc", f_npc, 32'h0040_0014);
        upd(32'h0040_0010, 1'b1, 32'h0040_0100);
        chk("t1_taken", f_taken, 0);
        upd(32'h0040_0010, 1'b1, 32'h0040_0100);
        upd(32'h0040_0010, 1'b1, 32'h0040_0100);
        upd(32'h0040_0010, 1'b1, 32'h0040_0100);
        chk("t4_taken", f_taken, 1);
        upd(32'h0040_0010, 1'b0, 32'h0);
        chk("sat_nt1_taken", f_taken, 1);
        upd(32'h0040_0010, 1'b0, 32'h0);
        chk("sat_nt2_taken", f_taken, 0);

        // Aliasing
        do_reset();
        upd(32'h0040_0010, 1'b1, 32'h0040_0100);
        upd(32'h0040_0050, 1'b1, 32'h0040_0200);
        f_pc = 32'h0040_0010;
        #1;
        chk("alias_old_hit", f_hit, 0);
        chk("alias_old_npc", f_npc, 32'h0040_0014);
        f_pc = 32'h0040_0050;
        #1;
        chk("alias_new_hit", f_hit, 1);
        chk("alias_new_npc", f_npc, 32'h0040_0200);

        // Same-cycle lookup and update
        do_reset();
        upd(32'h0040_0010, 1'b1, 32'h0040_0100);
        f_pc = 32'h0040_0010;
        u_valid = 1'b1;
        u_pc = 32'h0040_0010;
        u_taken = 1'b1;
        u_target = 32'h0040_0300;
        u_pred_npc = 32'h0040_0100;
        #1;
        chk("same_old_npc", f_npc, 32'h0040_0100);
        tick();
        u_valid = 1'b0;
        #1;
        chk("same_new_npc", f_npc, 32'h0040_0300);

        // Reset coinciding with an update
        resetn = 1'b0;
        u_valid = 1'b1;
        u_pc = 32'h0040_0020;
        u_taken = 1'b1;
        u_target = 32'h0040_0800;
        u_pred_npc = 32'h0;
        f_pc = 32'h0040_0010;
        #1;
        chk("inrst_hit", f_hit, 0);
        chk("inrst_npc", f_npc, 32'h0040_0014);
        chk("inrst_mis", u_mispredict, 0);
        tick();
        tick();
        resetn = 1'b1;
        u_valid = 1'b0;
        f_pc = 32'h0040_0020;
        #1;
        chk("postrst_hit", f_hit, 0);
        f_pc = 32'h0040_0010;
        #1;
        chk("postrst_hit2", f_hit, 0);

        // Mispredict vector table
        for (int i = 0; i < 6; i++) begin
            u_valid = vecs[i].v;
            u_pc = vecs[i].pc;
            u_taken = vecs[i].t;
            u_target = vecs[i].tgt;
            u_pred_taken = vecs[i].pt;
            u_pred_npc = vecs[i].pnpc;
            #1;
            chk($sformatf("vec%0d_mis", i), u_mispredict, vecs[i].em);
            chk($sformatf("vec%0d_fix", i), u_fix_pc, vecs[i].efix);
            tick();
        end
        u_valid = 1'b0;

`ifdef BP_STATS_EN
        do_reset();
        for (int k = 0; k < 5; k++) begin
            u_valid = 1'b1;
            u_pc = 32'h0040_0010;
            u_taken = 1'b1;
            u_target = 32'h0040_0100;
            u_pred_npc = (k < 2) ? 32'h0040_0014 : 32'h0040_0100;
            tick();
        end
        u_valid = 1'b0;
        chk("stat_lookups", stat_lookups, 5);
        chk("stat_mispred", stat_mispred, 2);
        stat_clr = 1'b1;
        u_valid = 1'b1;
        u_pred_npc = 32'h0;
        tick();
        stat_clr = 1'b0;
        u_valid = 1'b0;
        chk("stat_clr_lookups", stat_lookups, 0);
        chk("stat_clr_mispred", stat_mispred, 0);
`endif

        // Randomized run against the reference
        do_reset();
        m_reset();
        for (int n = 0; n < 600; n++) begin
            resetn = ($urandom_range(0, 49) != 0);
            f_pc = pool[$urandom_range(0, 5)];
            u_valid = $urandom_range(0, 1);
            u_pc = pool[$urandom_range(0, 5)];
            u_taken = ($urandom_range(0, 3) != 0);
            u_target = {$urandom_range(0, 15), 2'b00} + 32'h0040_1000;
            m_predict(u_pc, hit, tk, npc);
            if (!resetn) begin
                tk = 0;
                npc = u_pc + 32'd4;
            end
            u_pred_taken = tk;
            u_pred_npc = $urandom_range(0, 1) ? npc : u_target;
            fix = u_taken ? u_target : u_pc + 32'd4;
            m_predict(f_pc, hit, tk, npc);
            if (!resetn) begin
                hit = 0;
                tk = 0;
                npc = f_pc + 32'd4;
            end
            #1;
            chk("rnd_hit", f_hit, hit);
            chk("rnd_taken", f_taken, tk);
            chk("rnd_npc", f_npc, npc);
            chk("rnd_fix", u_fix_pc, fix);
            chk("rnd_mis", u_mispredict,
                resetn && u_valid && (u_pred_npc != fix));
            tick();
            if (!resetn) m_reset();
            else if (u_valid) m_update(u_pc, u_taken, u_target);
        end
        resetn = 1'b1;
        u_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
